pw_pattern_match: RTL and testbench
===================================

Name: pw_pattern_match

Overview:
- Stream pattern matcher in the front-end clock domain, directly upstream of the register/FIFO block.
- Consumes the sniffed USB byte stream plus the pattern, mask, action and length configuration that the register block drives.
- Produces the one-shot match pulse that the register block synchronises into the USB clock domain to clear arm; the trigger generator also consumes it.
- Sliding-window or packet-anchored comparison over the last N received bytes, with per-bit mask.

Parameters:
- pPATTERN_BYTES, 8, maximum pattern length in bytes; sets shift-register depth.
- pCOUNT_WIDTH, 8, width of the bytes-since-arm and bytes-since-packet-start saturating counters.

Ports:
- fe_clk  in  1  front-end capture clock.
- reset_n  in  1  asynchronous, active-low reset.
- I_arm  in  1  arm level, already in the fe_clk domain.
- I_data  in  8  received byte.
- I_data_valid  in  1  I_data qualifier, one cycle per byte.
- I_pkt_start  in  1  marks I_data as first byte of a packet; only meaningful with I_data_valid.
- I_pattern  in  8*pPATTERN_BYTES  byte k is compared against the byte received k bytes before the newest.
- I_pattern_mask  in  8*pPATTERN_BYTES  bit=1 means compare this bit.
- I_pattern_action  in  2  match mode.
- I_pattern_bytes  in  8  active pattern length.
- O_match  out  1  single-cycle match pulse.
- O_matched  out  1  sticky match flag; cleared on re-arm.
- O_armed  out  1  matcher is armed and searching.

Behaviour:
- Reset (async, reset_n=0): all outputs 0; shift register, counters and state cleared.
- Action encodings:
  - 00 = OFF: never match.
  - 01 = SLIDE: match at any byte position.
  - 10 = ANCHOR: match only when the window ends exactly I_pattern_bytes bytes after a packet start.
  - 11 = reserved, behaves as SLIDE.
- Effective length L = min(I_pattern_bytes, pPATTERN_BYTES). L=0 means never match.
- FSM states:
  - IDLE → SEARCH on I_arm rising edge (registered edge detect). Also clears the shift register, both counters and O_matched.
  - SEARCH → DONE on match.
  - SEARCH or DONE → IDLE on I_arm low.
  - DONE holds until I_arm falls; a new rising edge is required to re-arm.
- O_armed = 1 in SEARCH only.
- Shift register: on I_data_valid, window shifts by one byte with I_data entering byte 0. Holds otherwise.
- Bytes-since-arm counter: increments per valid byte, saturates at all-ones.
- Bytes-since-packet-start counter: loads 1 when I_data_valid and I_pkt_start are both high; else increments per valid byte; saturates.
- Compare stage (registered, one cycle after shift): match_raw is true when all of the following hold:
  - for every k < L, (window[k] XOR pattern[k]) AND mask[k] == 0;
  - bytes-since-arm ≥ L (stale bytes never match);
  - in ANCHOR mode, bytes-since-packet-start == L.
- The compare is evaluated only in the cycle after a valid byte.
- Latency: O_match goes high exactly 2 fe_clk cycles after the I_data_valid cycle of the final matching byte, for exactly 1 cycle. O_matched rises in the same cycle and stays high.
- Only the first match per arm produces a pulse.
- Configuration inputs are quasi-static (written while disarmed); a change while in SEARCH takes effect on the next compare without a glitch pulse.
- I_arm falling in the same cycle as match_raw: no pulse; go to IDLE.
- I_pkt_start without I_data_valid is ignored.

Decomposition:
- defines.v gains:
  - PW_ACTION_OFF/SLIDE/ANCHOR/RSVD encodings;
  - matcher FSM state constants.
- Sub-module pw_window_compare: purely combinational masked compare of window vs pattern with length L, returning the hit bit. Instantiated once.

Test Plan:
- Reset mid-stream: drive bytes, pull reset_n low asynchronously between edges → O_match/O_matched/O_armed 0 immediately; window cleared.
- SLIDE, L=2, pattern 0xA5 (byte1) 0x5A (byte0), mask 0xFFFF; arm, send 11 A5 5A → O_match one-cycle pulse 2 cycles after the 5A valid; further A5 5A → no pulse; O_matched stays 1.
- Mask: pattern byte0 = 0x00, mask byte0 = 0x0F, L=1; send 0xF1 → no match; send 0xF0 → match.
- ANCHOR, L=3, pattern C3 00 FF; send packet [C3 00 FF] → match. Send packet [2D C3 00 FF] → no match.
- Stale guard: SLIDE, L=4, pattern all 0x00, full mask; arm and send 3 bytes of 0x00 → no match; 4th 0x00 → match.
- L=0, L>pPATTERN_BYTES, and OFF: I_pattern_bytes=0 → never match; I_pattern_bytes=20 → behaves as L=8; action 00 → never match; re-arm (I_arm low then high) after a match → O_matched cleared and a new match is allowed.

Source files
------------

// File: rtl/pw_pattern_match_pkg.sv
// Shared types for the pattern matcher: action encodings, FSM states and small helpers.
package pw_pattern_match_pkg;

    localparam int PW_BYTE_W = 8;

    typedef enum logic [1:0] {
        PW_ACTION_OFF    = 2'b00,
        PW_ACTION_SLIDE  = 2'b01,
        PW_ACTION_ANCHOR = 2'b10,
        PW_ACTION_RSVD   = 2'b11
    } pw_action_e;

    typedef enum logic [1:0] {
        PW_ST_IDLE   = 2'b00,
        PW_ST_SEARCH = 2'b01,
        PW_ST_DONE   = 2'b10
    } pw_state_e;

    // The reserved encoding falls back to sliding behaviour, so only ANCHOR needs the packet check.
    function automatic logic action_is_anchor(input pw_action_e action);
        return action == PW_ACTION_ANCHOR;
    endfunction

    function automatic logic action_is_enabled(input pw_action_e action);
        return action != PW_ACTION_OFF;
    endfunction

endpackage

// File: rtl/pw_window_compare.sv
// Combinational masked compare of the received-byte window against the pattern over the first len bytes.
module pw_window_compare
    import pw_pattern_match_pkg::*;
#(
    parameter int pPATTERN_BYTES = 8
) (
    input  logic [PW_BYTE_W*pPATTERN_BYTES-1:0] window,
    input  logic [PW_BYTE_W*pPATTERN_BYTES-1:0] pattern,
    input  logic [PW_BYTE_W*pPATTERN_BYTES-1:0] mask,
    input  logic [7:0]                          len,
    output logic                                hit
);

    // A zero length never hits; otherwise any masked bit difference in the active bytes clears the hit.
    always_comb begin
        hit = (len != 8'd0);
        for (int k = 0; k < pPATTERN_BYTES; k++) begin
            if ((k < int'(len)) &&
                (((window[PW_BYTE_W*k +: PW_BYTE_W] ^ pattern[PW_BYTE_W*k +: PW_BYTE_W]) &
                  mask[PW_BYTE_W*k +: PW_BYTE_W]) != '0)) begin
                hit = 1'b0;
            end
        end
    end

endmodule

// File: rtl/pw_pattern_match.sv
// Stream pattern matcher: shifts sniffed bytes into a window, compares it against the configured
// masked pattern once per received byte and emits a single match pulse per arm.
module pw_pattern_match
    import pw_pattern_match_pkg::*;
#(
    parameter int pPATTERN_BYTES = 8,
    parameter int pCOUNT_WIDTH   = 8
) (
    input  logic                          fe_clk,
    input  logic                          reset_n,
    input  logic                          I_arm,
    input  logic [7:0]                    I_data,
    input  logic                          I_data_valid,
    input  logic                          I_pkt_start,
    input  logic [8*pPATTERN_BYTES-1:0]   I_pattern,
    input  logic [8*pPATTERN_BYTES-1:0]   I_pattern_mask,
    input  logic [1:0]                    I_pattern_action,
    input  logic [7:0]                    I_pattern_bytes,
    output logic                          O_match,
    output logic                          O_matched,
    output logic                          O_armed
);

    localparam int              WIN_W   = PW_BYTE_W * pPATTERN_BYTES;
    localparam logic [7:0]      MAX_LEN = 8'(pPATTERN_BYTES);
    localparam logic [pCOUNT_WIDTH-1:0] CNT_ONE = {{(pCOUNT_WIDTH-1){1'b0}}, 1'b1};

    pw_state_e                 state;
    pw_state_e                 state_next;
    pw_action_e                action;
    logic                      arm_q;
    logic                      arm_rise;
    logic                      arm_clear;
    logic [WIN_W-1:0]          window;
    logic [pCOUNT_WIDTH-1:0]   arm_cnt;
    logic [pCOUNT_WIDTH-1:0]   pkt_cnt;
    logic                      cmp_valid;
    logic [7:0]                eff_len;
    logic                      window_hit;
    logic                      len_ok;
    logic                      anchor_ok;
    logic                      match_raw;
    logic                      match_fire;
    logic                      match_q;
    logic                      matched_q;

    assign action    = pw_action_e'(I_pattern_action);
    assign arm_rise  = I_arm & ~arm_q;
    assign arm_clear = (state == PW_ST_IDLE) && arm_rise;
    assign eff_len   = (I_pattern_bytes > MAX_LEN) ? MAX_LEN : I_pattern_bytes;

    pw_window_compare #(
        .pPATTERN_BYTES (pPATTERN_BYTES)
    ) u_window_compare (
        .window  (window),
        .pattern (I_pattern),
        .mask    (I_pattern_mask),
        .len     (eff_len),
        .hit     (window_hit)
    );

    // Stale-byte guard and packet anchoring are judged against the same effective length as the compare.
    assign len_ok    = (32'(arm_cnt) >= 32'(eff_len));
    assign anchor_ok = !action_is_anchor(action) || (32'(pkt_cnt) == 32'(eff_len));
    assign match_raw = cmp_valid && window_hit && action_is_enabled(action) && len_ok && anchor_ok;

    // Registered copy of arm for rising-edge detection.
    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_q <= 1'b0;
        end else begin
            arm_q <= I_arm;
        end
    end

    // Byte window and counters; cleared on arming, advanced once per valid byte.
    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            window    <= '0;
            arm_cnt   <= '0;
            pkt_cnt   <= '0;
            cmp_valid <= 1'b0;
        end else if (arm_clear) begin
            window    <= '0;
            arm_cnt   <= '0;
            pkt_cnt   <= '0;
            cmp_valid <= 1'b0;
        end else begin
            cmp_valid <= I_data_valid;
            if (I_data_valid) begin
                window <= {window[WIN_W-PW_BYTE_W-1:0], I_data};
                if (arm_cnt != '1) begin
                    arm_cnt <= arm_cnt + 1'b1;
                end
                if (I_pkt_start) begin
                    pkt_cnt <= CNT_ONE;
                end else if (pkt_cnt != '1) begin
                    pkt_cnt <= pkt_cnt + 1'b1;
                end
            end
        end
    end

    // Next-state logic; a falling arm always wins over a simultaneous match so no pulse escapes.
    always_comb begin
        state_next = state;
        match_fire = 1'b0;
        case (state)
            PW_ST_IDLE: begin
                if (arm_rise) begin
                    state_next = PW_ST_SEARCH;
                end
            end
            PW_ST_SEARCH: begin
                if (!I_arm) begin
                    state_next = PW_ST_IDLE;
                end else if (match_raw) begin
                    state_next = PW_ST_DONE;
                    match_fire = 1'b1;
                end
            end
            PW_ST_DONE: begin
                if (!I_arm) begin
                    state_next = PW_ST_IDLE;
                end
            end
            default: begin
                state_next = PW_ST_IDLE;
            end
        endcase
    end

    // State register plus the match pulse and sticky flag, which only re-arming clears.
    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= PW_ST_IDLE;
            match_q   <= 1'b0;
            matched_q <= 1'b0;
        end else begin
            state   <= state_next;
            match_q <= match_fire;
            if (arm_clear) begin
                matched_q <= 1'b0;
            end else if (match_fire) begin
                matched_q <= 1'b1;
            end
        end
    end

    assign O_match   = match_q;
    assign O_matched = matched_q;
    assign O_armed   = (state == PW_ST_SEARCH);

endmodule

// File: tb/tb_pw_pattern_match.sv
// Directed testbench for pw_pattern_match with hand-computed expected pulse timing and flags.
module tb_pw_pattern_match;

    logic        fe_clk;
    logic        reset_n;
    logic        I_arm;
    logic [7:0]  I_data;
    logic        I_data_valid;
    logic        I_pkt_start;
    logic [63:0] I_pattern;
    logic [63:0] I_pattern_mask;
    logic [1:0]  I_pattern_action;
    logic [7:0]  I_pattern_bytes;
    logic        O_match;
    logic        O_matched;
    logic        O_armed;

    int assert_count = 0;
    int fail_count   = 0;

    pw_pattern_match #(
        .pPATTERN_BYTES (8),
        .pCOUNT_WIDTH   (8)
    ) dut (
        .fe_clk           (fe_clk),
        .reset_n          (reset_n),
        .I_arm            (I_arm),
        .I_data           (I_data),
        .I_data_valid     (I_data_valid),
        .I_pkt_start      (I_pkt_start),
        .I_pattern        (I_pattern),
        .I_pattern_mask   (I_pattern_mask),
        .I_pattern_action (I_pattern_action),
        .I_pattern_bytes  (I_pattern_bytes),
        .O_match          (O_match),
        .O_matched        (O_matched),
        .O_armed          (O_armed)
    );

    // Free-running front-end clock, 10 ns period.
    initial begin
        fe_clk = 1'b0;
        forever #5 fe_clk = ~fe_clk;
    end

    // Single comparison point: counts every check and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge fe_clk);
        #1;
    endtask

    task automatic configure(input logic [63:0] pat, input logic [63:0] msk,
                             input logic [1:0] act, input logic [7:0] nbytes);
        I_pattern        = pat;
        I_pattern_mask   = msk;
        I_pattern_action = act;
        I_pattern_bytes  = nbytes;
    endtask

    task automatic armMatcher();
        I_arm = 1'b1;
        waitCycles(2);
    endtask

    task automatic disarmMatcher();
        I_arm = 1'b0;
        waitCycles(2);
    endtask

    // Drives one valid byte and checks O_match is low one cycle after, equal to exp_pulse two cycles after,
    // and low again on the third cycle.
    task automatic applyStimulus(input logic [7:0] d, input logic start, input logic exp_pulse, input string tag);
        I_data       = d;
        I_data_valid = 1'b1;
        I_pkt_start  = start;
        waitCycles(1);
        I_data_valid = 1'b0;
        I_pkt_start  = 1'b0;
        checkOutput($sformatf("%s early", tag), {31'd0, O_match}, 32'd0);
        waitCycles(1);
        checkOutput($sformatf("%s pulse", tag), {31'd0, O_match}, {31'd0, exp_pulse});
        waitCycles(1);
        checkOutput($sformatf("%s after", tag), {31'd0, O_match}, 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        I_arm = 1'b0;
        I_data = 8'h00;
        I_data_valid = 1'b0;
        I_pkt_start = 1'b0;
        configure(64'h0, 64'h0, 2'b00, 8'd0);

        // Reset state
        waitCycles(2);
        checkOutput("reset match", {31'd0, O_match}, 32'd0);
        checkOutput("reset matched", {31'd0, O_matched}, 32'd0);
        checkOutput("reset armed", {31'd0, O_armed}, 32'd0);
        reset_n = 1'b1;
        waitCycles(2);

        // SLIDE, L=2, A5 5A
        configure(64'hA55A, 64'hFFFF, 2'b01, 8'd2);
        armMatcher();
        checkOutput("slide armed", {31'd0, O_armed}, 32'd1);
        checkOutput("slide matched0", {31'd0, O_matched}, 32'd0);
        applyStimulus(8'h11, 1'b0, 1'b0, "slide 11");
        applyStimulus(8'hA5, 1'b0, 1'b0, "slide A5");
        applyStimulus(8'h5A, 1'b0, 1'b1, "slide 5A");
        checkOutput("slide matched1", {31'd0, O_matched}, 32'd1);
        checkOutput("slide done armed", {31'd0, O_armed}, 32'd0);
        applyStimulus(8'hA5, 1'b0, 1'b0, "slide again A5");
        applyStimulus(8'h5A, 1'b0, 1'b0, "slide again 5A");
        checkOutput("slide sticky", {31'd0, O_matched}, 32'd1);

        // Re-arm clears the sticky flag and allows a new match
        disarmMatcher();
        checkOutput("disarm sticky", {31'd0, O_matched}, 32'd1);
        checkOutput("disarm armed", {31'd0, O_armed}, 32'd0);
        armMatcher();
        checkOutput("rearm matched", {31'd0, O_matched}, 32'd0);
        checkOutput("rearm armed", {31'd0, O_armed}, 32'd1);
        applyStimulus(8'hA5, 1'b0, 1'b0, "rearm A5");
        applyStimulus(8'h5A, 1'b0, 1'b1, "rearm 5A");

        // Per-bit mask, L=1
        disarmMatcher();
        configure(64'h00, 64'h0F, 2'b01, 8'd1);
        armMatcher();
        applyStimulus(8'hF1, 1'b0, 1'b0, "mask F1");
        applyStimulus(8'hF0, 1'b0, 1'b1, "mask F0");

        // ANCHOR, L=3, C3 00 FF
        disarmMatcher();
        configure(64'hC300FF, 64'hFFFFFF, 2'b10, 8'd3);
        armMatcher();
        applyStimulus(8'h2D, 1'b1, 1'b0, "anchor4 2D");
        applyStimulus(8'hC3, 1'b0, 1'b0, "anchor4 C3");
        applyStimulus(8'h00, 1'b0, 1'b0, "anchor4 00");
        applyStimulus(8'hFF, 1'b0, 1'b0, "anchor4 FF");
        applyStimulus(8'hC3, 1'b1, 1'b0, "anchor3 C3");
        applyStimulus(8'h00, 1'b0, 1'b0, "anchor3 00");
        applyStimulus(8'hFF, 1'b0, 1'b1, "anchor3 FF");

        // Packet start without a valid byte is ignored
        disarmMatcher();
        armMatcher();
        applyStimulus(8'hC3, 1'b1, 1'b0, "lonestart C3");
        applyStimulus(8'h00, 1'b0, 1'b0, "lonestart 00");
        I_pkt_start = 1'b1;
        waitCycles(1);
        I_pkt_start = 1'b0;
        applyStimulus(8'hFF, 1'b0, 1'b1, "lonestart FF");

        // Stale guard: zeroed window must not match before L bytes arrive
        disarmMatcher();
        configure(64'h0, 64'hFFFFFFFF, 2'b01, 8'd4);
        armMatcher();
        applyStimulus(8'h00, 1'b0, 1'b0, "stale 1");
        applyStimulus(8'h00, 1'b0, 1'b0, "stale 2");
        applyStimulus(8'h00, 1'b0, 1'b0, "stale 3");
        applyStimulus(8'h00, 1'b0, 1'b1, "stale 4");

        // L=0 never matches
        disarmMatcher();
        configure(64'h0, 64'hFFFFFFFFFFFFFFFF, 2'b01, 8'd0);
        armMatcher();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'h00, 1'b0, 1'b0, $sformatf("len0 %0d", i));
        end
        checkOutput("len0 armed", {31'd0, O_armed}, 32'd1);

        // Length 20 clamps to the 8-byte window
        disarmMatcher();
        configure(64'h0102030405060708, 64'hFFFFFFFFFFFFFFFF, 2'b01, 8'd20);
        armMatcher();
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(8'(i), 1'b0, (i == 8), $sformatf("len20 %0d", i));
        end

        // Reserved action behaves as SLIDE
        disarmMatcher();
        configure(64'h0102030405060708, 64'hFFFFFFFFFFFFFFFF, 2'b11, 8'd8);
        armMatcher();
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(8'(i), 1'b0, (i == 8), $sformatf("rsvd %0d", i));
        end

        // OFF never matches
        disarmMatcher();
        configure(64'h0102030405060708, 64'hFFFFFFFFFFFFFFFF, 2'b00, 8'd8);
        armMatcher();
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(8'(i), 1'b0, 1'b0, $sformatf("off %0d", i));
        end
        checkOutput("off armed", {31'd0, O_armed}, 32'd1);

        // Arm falling in the same cycle as the raw match suppresses the pulse
        disarmMatcher();
        configure(64'h77, 64'hFF, 2'b01, 8'd1);
        armMatcher();
        I_data = 8'h77;
        I_data_valid = 1'b1;
        waitCycles(1);
        I_data_valid = 1'b0;
        I_arm = 1'b0;
        checkOutput("armfall early", {31'd0, O_match}, 32'd0);
        waitCycles(1);
        checkOutput("armfall pulse", {31'd0, O_match}, 32'd0);
        checkOutput("armfall matched", {31'd0, O_matched}, 32'd0);
        checkOutput("armfall armed", {31'd0, O_armed}, 32'd0);
        waitCycles(2);

        // Asynchronous reset mid-stream while the match pulse is high
        configure(64'hA55A, 64'hFFFF, 2'b01, 8'd2);
        armMatcher();
        applyStimulus(8'h11, 1'b0, 1'b0, "rst 11");
        applyStimulus(8'hA5, 1'b0, 1'b0, "rst A5");
        I_data = 8'h5A;
        I_data_valid = 1'b1;
        waitCycles(1);
        I_data_valid = 1'b0;
        waitCycles(1);
        checkOutput("rst pre pulse", {31'd0, O_match}, 32'd1);
        checkOutput("rst pre matched", {31'd0, O_matched}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rst async match", {31'd0, O_match}, 32'd0);
        checkOutput("rst async matched", {31'd0, O_matched}, 32'd0);
        checkOutput("rst async armed", {31'd0, O_armed}, 32'd0);
        I_arm = 1'b0;
        waitCycles(2);
        reset_n = 1'b1;
        waitCycles(2);

        // Asynchronous reset while searching drops armed immediately
        armMatcher();
        checkOutput("rst2 armed", {31'd0, O_armed}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rst2 async armed", {31'd0, O_armed}, 32'd0);
        I_arm = 1'b0;
        waitCycles(2);
        reset_n = 1'b1;
        waitCycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
